jacobi_rot_buffer: RTL and testbench

Parametrised multi-lane result buffer between the rotation CORDIC and the Jacobi main controller. It replaces the fixed 2-lane AXI-stream FIFO. It adds credit-based issue gating: the CORDIC pipeline cannot stall, so the controller may launch a rotation only when buffer space is reserved for it. It also provides occupancy visibility, error flags and synchronous flush.

---
 rtl/jacobi_rot_buffer.sv | 65 ++++++
 tb/tb_jacobi_rot_buffer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/jacobi_rot_buffer.sv
// jacobi_rot_buffer: credit-gated multi-lane FWFT result buffer between the rotation CORDIC and the Jacobi controller
module jacobi_rot_buffer #(
  parameter int WIDTH = 16,
  parameter int LANES = 2,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH+1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   issue_i,
  output logic                   issue_ok_o,
  input  logic                   in_vld_i,
  input  logic [LANES*WIDTH-1:0] in_dat_i,
  output logic                   out_vld_o,
  output logic [LANES*WIDTH-1:0] out_dat_o,
  input  logic                   out_rdy_i,
  output logic [CNT_W-1:0]       count_o,
  output logic [CNT_W-1:0]       inflight_o,
  output logic [1:0]             err_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int DW = LANES*WIDTH;
  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic accept, pop, push, ret;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH-1) ? '0 : p + 1'b1;
  endfunction
  // stored plus outstanding results must always fit, since the CORDIC cannot be stalled
  assign issue_ok_o = ({1'b0, count_o} + {1'b0, inflight_o}) < (CNT_W+1)'(DEPTH);
  assign accept = issue_i && issue_ok_o;
  assign out_vld_o = count_o != '0;
  assign out_dat_o = mem[rd_ptr];
  assign pop = out_vld_o && out_rdy_i;
  assign push = in_vld_i && (count_o < CNT_W'(DEPTH) || pop);
  assign ret = in_vld_i && inflight_o != '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count_o <= '0;
      inflight_o <= '0;
      err_o <= '0;
    end else begin
      inflight_o <= inflight_o + CNT_W'(accept) - CNT_W'(ret);
      if (flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count_o <= '0;
        err_o <= '0;
      end else begin
        if (push) wr_ptr <= nxt(wr_ptr);
        if (pop) rd_ptr <= nxt(rd_ptr);
        count_o <= count_o + CNT_W'(push) - CNT_W'(pop);
        err_o <= err_o | {in_vld_i && inflight_o == '0, in_vld_i && !push};
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !flush_i) begin
      mem[wr_ptr] <= in_dat_i;
    end
endmodule

// File: tb/tb_jacobi_rot_buffer.sv
// tb_jacobi_rot_buffer: directed checks of credit gating, ordering, full/drop, flush and non-power-of-two wrap
module tb_jacobi_rot_buffer;
  localparam int D = 16;
  localparam int DB = 5;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic flush, issue, in_vld, out_rdy, issue_ok, out_vld;
  logic [31:0] in_dat, out_dat;
  logic [4:0] count, inflight;
  logic [1:0] err;
  logic issue_b, in_vld_b, out_rdy_b, ok_b, vld_b;
  logic [31:0] in_dat_b, dat_b;
  logic [2:0] cnt_b, inf_b;
  logic [1:0] err_b;
  int vectors = 0, misses = 0;
  jacobi_rot_buffer #(.WIDTH(16), .LANES(2), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .issue_i(issue), .issue_ok_o(issue_ok),
    .in_vld_i(in_vld), .in_dat_i(in_dat), .out_vld_o(out_vld), .out_dat_o(out_dat),
    .out_rdy_i(out_rdy), .count_o(count), .inflight_o(inflight), .err_o(err));
  jacobi_rot_buffer #(.WIDTH(16), .LANES(2), .DEPTH(DB)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush_i(1'b0), .issue_i(issue_b), .issue_ok_o(ok_b),
    .in_vld_i(in_vld_b), .in_dat_i(in_dat_b), .out_vld_o(vld_b), .out_dat_o(dat_b),
    .out_rdy_i(out_rdy_b), .count_o(cnt_b), .inflight_o(inf_b), .err_o(err_b));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      misses++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] word(input int k);
    return {~k[15:0], k[15:0]};
  endfunction
  logic [31:0] q[$];
  int sent, got;
  initial begin
    {flush, issue, in_vld, out_rdy, issue_b, in_vld_b, out_rdy_b} = '0;
    in_dat = '0;
    in_dat_b = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    #1;
    chk("rst_vld", out_vld, 0);
    chk("rst_cnt", count, 0);
    chk("rst_inf", inflight, 0);
    chk("rst_ok", issue_ok, 1);
    chk("rst_err", err, 0);
    chk("rst_dat", out_dat, 0);
    // 40 rotations through a 12-cycle CORDIC with a consumer that never stalls
    for (int c = 0; c <= 52; c++) begin
      issue = c < 40;
      in_vld = c >= 12 && c < 52;
      in_dat = word(c - 12);
      out_rdy = 1;
      step;
      chk("ord_vld", out_vld, c >= 12 && c < 52);
      if (c >= 12 && c < 52) chk("ord_dat", out_dat, word(c - 12));
      chk("ord_cnt", count <= 1, 1);
    end
    {issue, in_vld, out_rdy} = '0;
    chk("ord_inf", inflight, 0);
    chk("ord_end_cnt", count, 0);
    // credit exhaustion with the consumer stalled
    for (int i = 0; i < D; i++) begin
      chk("cr_ok", issue_ok, 1);
      issue = 1;
      step;
    end
    chk("cr_ok_low", issue_ok, 0);
    step;
    issue = 0;
    chk("cr_inf16", inflight, 16);
    repeat (10) step;
    for (int k = 0; k < D; k++) begin
      in_vld = 1;
      in_dat = word(k);
      step;
    end
    in_vld = 0;
    chk("cr_cnt", count, 16);
    chk("cr_inf0", inflight, 0);
    chk("cr_err", err, 0);
    chk("cr_ok_full", issue_ok, 0);
    chk("full_head", out_dat, word(0));
    in_vld = 1;
    in_dat = 32'hAAAA5555;
    out_rdy = 1;
    step;
    {in_vld, out_rdy} = '0;
    chk("full_pp_cnt", count, 16);
    chk("full_pp_err0", err[0], 0);
    in_vld = 1;
    in_dat = 32'hDEADBEEF;
    step;
    in_vld = 0;
    chk("full_drop_cnt", count, 16);
    chk("full_drop_err0", err[0], 1);
    out_rdy = 1;
    for (int k = 1; k <= D; k++) begin
      chk("drain_dat", out_dat, k < D ? word(k) : 32'hAAAA5555);
      step;
    end
    out_rdy = 0;
    chk("drain_vld", out_vld, 0);
    // flush keeps in-flight credits and counts a coincident issue
    issue = 1;
    repeat (5) step;
    issue = 0;
    for (int k = 0; k < 3; k++) begin
      in_vld = 1;
      in_dat = word(100 + k);
      step;
    end
    in_vld = 0;
    chk("fl_pre_cnt", count, 3);
    chk("fl_pre_inf", inflight, 2);
    flush = 1;
    issue = 1;
    step;
    {flush, issue} = '0;
    chk("fl_cnt", count, 0);
    chk("fl_inf", inflight, 3);
    chk("fl_err", err, 0);
    chk("fl_vld", out_vld, 0);
    for (int k = 0; k < 3; k++) begin
      in_vld = 1;
      in_dat = word(200 + k);
      step;
    end
    in_vld = 0;
    chk("fl_ret_cnt", count, 3);
    chk("fl_ret_inf", inflight, 0);
    chk("fl_ret_err", err, 0);
    chk("fl_ret_head", out_dat, word(200));
    in_vld = 1;
    in_dat = word(300);
    step;
    in_vld = 0;
    chk("unsol_err", err, 2'b10);
    chk("unsol_cnt", count, 4);
    chk("unsol_inf", inflight, 0);
    // DEPTH=5 instance: random backpressure drives the pointers around the ring
    sent = 0;
    got = 0;
    for (int cyc = 0; cyc < 400 && got < 13; cyc++) begin
      chk("wrap_vld", vld_b, q.size() != 0);
      if (q.size() != 0) chk("wrap_dat", dat_b, q[0]);
      out_rdy_b = 1'($urandom_range(0, 1));
      in_vld_b = sent < 13 && q.size() < DB && $urandom_range(0, 2) != 0;
      in_dat_b = word(500 + sent);
      if (out_rdy_b && q.size() != 0) begin
        void'(q.pop_front());
        got++;
      end
      if (in_vld_b) begin
        q.push_back(in_dat_b);
        sent++;
      end
      step;
    end
    {in_vld_b, out_rdy_b} = '0;
    chk("wrap_all", got, 13);
    chk("wrap_cnt", cnt_b, 0);
    chk("wrap_err0", err_b[0], 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end
endmodule
